rtc_field_editor: RTL

- Parametrised successor of the clock/timer data-entry block: a user-driven editor for N two-digit BCD fields (seconds, minutes, hours, day, month, year, or any subset).
- Edits a shadow copy of the live values, then commits the whole set in one write pulse to the timekeeping datapath.
- Adds features the previous block lacked:
  - per-press stepping with hold-to-auto-repeat
  - per-field limits
  - month/leap-year aware day limit
  - 12/24 h hour range
  - commit/abort
  - idle timeout

---
 rtl/rtc_field_editor.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rtc_field_editor.sv
// Shadow-copy editor for N two-digit BCD time/date fields. Edits are stepped per press or by
// hold-to-repeat. The shadow is range-checked continuously and committed in one write strobe.
module rtc_field_editor #(
  parameter int unsigned NUM_FIELDS = 6,
  parameter logic [8*NUM_FIELDS-1:0] FIELD_MIN = {8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00},
  parameter logic [8*NUM_FIELDS-1:0] FIELD_MAX = {8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59},
  parameter int unsigned HOUR_IDX = 2,
  parameter int unsigned DAY_IDX = 3,
  parameter int unsigned MONTH_IDX = 4,
  parameter int unsigned YEAR_IDX = 5,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000000,
  localparam int unsigned SelW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1,
  localparam int unsigned DataW = 8 * NUM_FIELDS
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             escribe_i,
  input  logic             aumenta_i,
  input  logic             disminuye_i,
  input  logic             corre_der_i,
  input  logic             corre_izq_i,
  input  logic             doce_24_i,
  input  logic             commit_i,
  input  logic             abort_i,
  input  logic [DataW-1:0] cur_values_i,
  output logic             editing_o,
  output logic [SelW-1:0]  field_sel_o,
  output logic [DataW-1:0] edit_values_o,
  output logic             wr_valid_o,
  output logic [DataW-1:0] wr_data_o
);

  localparam bit HourEn = HOUR_IDX < NUM_FIELDS;
  localparam bit DateEn = (DAY_IDX < NUM_FIELDS) && (MONTH_IDX < NUM_FIELDS) &&
                          (YEAR_IDX < NUM_FIELDS);
  localparam int HourI = HourEn ? int'(HOUR_IDX) : 0;
  localparam int DayI  = DateEn ? int'(DAY_IDX) : 0;
  localparam int MonI  = DateEn ? int'(MONTH_IDX) : 0;
  localparam int YrI   = DateEn ? int'(YEAR_IDX) : 0;

  typedef enum logic [1:0] {StIdle, StLoad, StEdit} state_e;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    return (v[3:0] == 4'd0) ? {v[7:4] - 4'd1, 4'd9} : {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  state_e          state_q;
  logic [7:0]      shadow_q [NUM_FIELDS];
  logic [SelW-1:0] sel_q, sel_d;
  logic            editing_q, wr_valid_q;
  logic [DataW-1:0] wr_data_q;
  logic [31:0]     hold_q, rep_q, to_q;
  logic [6:0]      btn, btn_q, btn_e;

  logic [7:0] lo [NUM_FIELDS];
  logic [7:0] hi_base [NUM_FIELDS];
  logic [7:0] hi [NUM_FIELDS];
  logic [7:0] loaded [NUM_FIELDS];
  logic [7:0] fixed [NUM_FIELDS];
  logic [7:0] next_sh [NUM_FIELDS];
  logic [7:0] day_max, mon, yr, cur_f, step_val;
  logic       leap, up_only, dn_only, held, rep_fire, step_up, step_dn, move_r, move_l, any_e;

  // Bit order: escribe, aumenta, disminuye, corre_der, corre_izq, commit, abort.
  assign btn   = {abort_i, commit_i, corre_izq_i, corre_der_i, disminuye_i, aumenta_i, escribe_i};
  assign btn_e = btn & ~btn_q;
  assign any_e = |btn_e;

  always_comb begin
    mon = shadow_q[MonI];
    yr  = shadow_q[YrI];
    // year % 4 == 0 on BCD digits: 10*t + u is a multiple of 4 iff (2*t + u) is.
    leap = yr[4] ? (yr[3:0] == 4'd2 || yr[3:0] == 4'd6)
                 : (yr[3:0] == 4'd0 || yr[3:0] == 4'd4 || yr[3:0] == 4'd8);
    case (mon)
      8'h04, 8'h06, 8'h09, 8'h11: day_max = 8'h30;
      8'h02:                      day_max = leap ? 8'h29 : 8'h28;
      default:                    day_max = 8'h31;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_FIELDS; i++) begin
      lo[i]      = FIELD_MIN[8*i +: 8];
      hi_base[i] = FIELD_MAX[8*i +: 8];
      if (HourEn && i == HourI) begin
        lo[i]      = doce_24_i ? 8'h01 : 8'h00;
        hi_base[i] = doce_24_i ? 8'h12 : 8'h23;
      end
      hi[i] = hi_base[i];
      if (DateEn && i == DayI) hi[i] = day_max;

      loaded[i] = cur_values_i[8*i +: 8];
      if (!is_bcd(loaded[i]) || loaded[i] < lo[i] || loaded[i] > hi_base[i]) loaded[i] = lo[i];

      fixed[i] = shadow_q[i];
      if (HourEn && i == HourI && (fixed[i] < lo[i] || fixed[i] > hi[i])) fixed[i] = lo[i];
      if (DateEn && i == DayI && fixed[i] > hi[i]) fixed[i] = hi[i];
    end
  end

  always_comb begin
    up_only  = aumenta_i & ~disminuye_i;
    dn_only  = disminuye_i & ~aumenta_i;
    held     = up_only | dn_only;
    rep_fire = held && !btn_e[1] && !btn_e[2] && (hold_q >= HOLD_CYCLES) &&
               (rep_q == 32'(REPEAT_CYCLES - 1));
    step_up  = (btn_e[1] & ~disminuye_i) | (rep_fire & up_only);
    step_dn  = (btn_e[2] & ~aumenta_i) | (rep_fire & dn_only);
    move_r   = !(step_up || step_dn) && btn_e[3] && !corre_izq_i;
    move_l   = !(step_up || step_dn) && btn_e[4] && !corre_der_i;

    cur_f    = fixed[sel_q];
    step_val = cur_f;
    if (step_up) step_val = (cur_f >= hi[sel_q]) ? lo[sel_q] : bcd_inc(cur_f);
    if (step_dn) step_val = (cur_f <= lo[sel_q]) ? hi[sel_q] : bcd_dec(cur_f);
    next_sh        = fixed;
    next_sh[sel_q] = step_val;

    sel_d = sel_q;
    if (move_r) sel_d = (sel_q == SelW'(NUM_FIELDS - 1)) ? '0 : sel_q + 1'b1;
    if (move_l) sel_d = (sel_q == '0) ? SelW'(NUM_FIELDS - 1) : sel_q - 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_FIELDS; i++) edit_values_o[8*i +: 8] = shadow_q[i];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      shadow_q   <= '{default: '0};
      sel_q      <= '0;
      editing_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
      hold_q     <= '0;
      rep_q      <= '0;
      to_q       <= '0;
      btn_q      <= '0;
    end else begin
      btn_q      <= btn;
      wr_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          hold_q <= '0;
          rep_q  <= '0;
          to_q   <= '0;
          if (btn_e[0]) begin
            state_q   <= StLoad;
            editing_q <= 1'b1;
          end
        end
        StLoad: begin
          shadow_q <= loaded;
          sel_q    <= '0;
          state_q  <= StEdit;
        end
        StEdit: begin
          if (btn_e[5]) begin
            wr_data_q  <= edit_values_o;
            wr_valid_q <= 1'b1;
            state_q    <= StIdle;
            editing_q  <= 1'b0;
          end else if (btn_e[6] || (!any_e && to_q >= 32'(TIMEOUT_CYCLES - 1))) begin
            state_q   <= StIdle;
            editing_q <= 1'b0;
          end else begin
            shadow_q <= next_sh;
            sel_q    <= sel_d;
            to_q     <= any_e ? '0 : to_q + 32'd1;
            // Repeat starts REPEAT_CYCLES after the hold interval has elapsed.
            if (btn_e[1] || btn_e[2] || move_r || move_l || !held) begin
              hold_q <= '0;
              rep_q  <= '0;
            end else if (hold_q < HOLD_CYCLES) begin
              hold_q <= hold_q + 32'd1;
            end else if (rep_fire) begin
              rep_q <= '0;
            end else begin
              rep_q <= rep_q + 32'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign editing_o   = editing_q;
  assign field_sel_o = sel_q;
  assign wr_valid_o  = wr_valid_q;
  assign wr_data_o   = wr_data_q;

endmodule
